// File: rtl/arith_unit_seq.sv
// Handshaked add / subtract / unsigned-multiply unit with valid/ready on both sides.
// Add and sub take one cycle. Multiply is an iterative shift-add that handles one multiplier bit per cycle.
module arith_unit_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic               carry,
  output logic               ovf,
  output logic               zero,
  output logic               err
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t               state, state_nx;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_nx;
  logic                 accept;
  logic                 last;
  logic                 sub;
  logic [WIDTH-1:0]     bx;
  logic [WIDTH:0]       sum;
  logic                 as_ovf;

  assign accept    = in_valid & in_ready;
  assign last      = (state == MUL) && (cnt == CW'(WIDTH - 1));
  // Gated with rst_n so the source never sees ready while the unit is held in reset.
  assign in_ready  = (state == IDLE) & rst_n;
  assign out_valid = (state == DONE);

  // Add and sub share one adder. Sub feeds in the inverted b and a carry-in of 1.
  assign sub    = (op == OP_SUB);
  assign bx     = b ^ {WIDTH{sub}};
  assign sum    = {1'b0, a} + {1'b0, bx} + (WIDTH+1)'(sub);
  assign as_ovf = (a[WIDTH-1] == bx[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);

  assign acc_nx = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (op == OP_MUL) ? MUL : DONE;
      MUL:     if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The accept edge already adds the b[0] partial product.
  // The MUL state then adds the remaining WIDTH-1 partial products, with cnt running from 1 to WIDTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      y      <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      err    <= 1'b0;
    end else if (accept) begin
      case (op)
        OP_MUL: begin
          mcand  <= (2*WIDTH)'(a) << 1;
          mplier <= b >> 1;
          acc    <= b[0] ? (2*WIDTH)'(a) : '0;
          cnt    <= CW'(1);
        end
        OP_RSV: begin
          y     <= '0;
          carry <= 1'b0;
          ovf   <= 1'b0;
          zero  <= 1'b1;
          err   <= 1'b1;
        end
        default: begin
          y     <= (2*WIDTH)'(sum[WIDTH-1:0]);
          carry <= sum[WIDTH];
          ovf   <= as_ovf;
          zero  <= (sum[WIDTH-1:0] == '0);
          err   <= 1'b0;
        end
      endcase
    end else if (state == MUL) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (last) begin
        y     <= acc_nx;
        carry <= 1'b0;
        ovf   <= 1'b0;
        zero  <= (acc_nx == '0);
        err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arith_unit_seq.sv
// Directed testbench for arith_unit_seq. Expected values are hand-computed.
// A second instance with WIDTH=16 covers the wide multiply.
module tb_arith_unit_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  op;
  logic [7:0]  a, b;
  logic [15:0] y;
  logic        carry, ovf, zero, err;

  logic        v16, r16, ov16, or16;
  logic [1:0]  op16;
  logic [15:0] a16, b16;
  logic [31:0] y16;
  logic        c16, o16, z16, e16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arith_unit_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .carry(carry), .ovf(ovf), .zero(zero), .err(err));

  arith_unit_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16), .op(op16),
    .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16), .y(y16),
    .carry(c16), .ovf(o16), .zero(z16), .err(e16));

  // Drive one operation and return #1 after the accept edge. The inputs are then scrambled.
  task automatic issue(input logic [1:0] o, input logic [7:0] x, input logic [7:0] z);
    @(negedge clk);
    op = o; a = x; b = z; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~x; b = ~z; op = 2'b00;
  endtask

  // Latency is the number of rising edges from the accept edge (inclusive) until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic handshake();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_cmp++; if ({y, carry, ovf, zero, err} !== 20'h0) begin n_err++; $display("FAIL rst_outs got y=%h flags=%b%b%b%b exp all 0", y, carry, ovf, zero, err); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_add();
    int lat;
    issue(2'b00, 8'd200, 8'd100);
    wait_valid(lat);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL add_latency got %0d exp 1", lat); end
    n_cmp++; if ({y, carry, ovf, zero, err} !== {16'h002C, 4'b1000}) begin n_err++; $display("FAIL add_result got y=%h c%b o%b z%b e%b exp y=002c c1 o0 z0 e0", y, carry, ovf, zero, err); end
    handshake();
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL add_return_idle got rdy=%b vld=%b exp 1/0", in_ready, out_valid); end
    n_cmp++; if (y !== 16'h002C) begin n_err++; $display("FAIL add_y_held got %h exp 002c", y); end
  endtask

  task automatic test_backpressure();
    int lat;
    issue(2'b00, 8'd10, 8'd20);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if ({out_valid, in_ready, y, carry, ovf, zero, err} !== {2'b10, 16'd30, 4'b0000}) begin
        n_err++; $display("FAIL bp_stable cyc %0d got vld=%b rdy=%b y=%h flags=%b%b%b%b exp 1 0 001e 0000", i, out_valid, in_ready, y, carry, ovf, zero, err);
      end
    end
    handshake();
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL bp_release got rdy=%b vld=%b exp 1/0", in_ready, out_valid); end
  endtask

  task automatic test_sub();
    int lat;
    issue(2'b01, 8'd5, 8'd7);
    wait_valid(lat);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL sub_latency got %0d exp 1", lat); end
    n_cmp++; if ({y, carry, ovf, zero, err} !== {16'h00FE, 4'b0000}) begin n_err++; $display("FAIL sub_5_7 got y=%h c%b o%b z%b e%b exp y=00fe c0 o0 z0 e0", y, carry, ovf, zero, err); end
    handshake();
    issue(2'b01, 8'h80, 8'h01);
    wait_valid(lat);
    n_cmp++; if ({y, carry, ovf, zero, err} !== {16'h007F, 4'b1100}) begin n_err++; $display("FAIL sub_80_1 got y=%h c%b o%b z%b e%b exp y=007f c1 o1 z0 e0", y, carry, ovf, zero, err); end
    handshake();
    issue(2'b01, 8'h33, 8'h33);
    wait_valid(lat);
    n_cmp++; if ({y, carry, ovf, zero, err} !== {16'h0000, 4'b1010}) begin n_err++; $display("FAIL sub_eq got y=%h c%b o%b z%b e%b exp y=0000 c1 o0 z1 e0", y, carry, ovf, zero, err); end
    handshake();
    issue(2'b00, 8'h7F, 8'h01);
    wait_valid(lat);
    n_cmp++; if ({y, carry, ovf, zero, err} !== {16'h0080, 4'b0100}) begin n_err++; $display("FAIL add_ovf got y=%h c%b o%b z%b e%b exp y=0080 c0 o1 z0 e0", y, carry, ovf, zero, err); end
    handshake();
  endtask

  task automatic test_reserved();
    int lat;
    issue(2'b11, 8'h12, 8'h34);
    wait_valid(lat);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL rsv_latency got %0d exp 1", lat); end
    n_cmp++; if ({y, carry, ovf, zero, err} !== {16'h0000, 4'b0011}) begin n_err++; $display("FAIL rsv_result got y=%h c%b o%b z%b e%b exp y=0000 c0 o0 z1 e1", y, carry, ovf, zero, err); end
    handshake();
  endtask

  task automatic test_mul();
    int lat;
    issue(2'b10, 8'd255, 8'd255);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mul_busy_ready got %b exp 0", in_ready); end
    wait_valid(lat);
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL mul_latency got %0d exp 8", lat); end
    n_cmp++; if ({y, carry, ovf, zero, err} !== {16'hFE01, 4'b0000}) begin n_err++; $display("FAIL mul_ff_ff got y=%h c%b o%b z%b e%b exp y=fe01 c0 o0 z0 e0", y, carry, ovf, zero, err); end
    handshake();
    issue(2'b10, 8'd0, 8'd77);
    wait_valid(lat);
    n_cmp++; if ({y, zero, err} !== {16'h0000, 2'b10}) begin n_err++; $display("FAIL mul_zero got y=%h z%b e%b exp y=0000 z1 e0", y, zero, err); end
    handshake();
    issue(2'b10, 8'd13, 8'd11);
    wait_valid(lat);
    n_cmp++; if ({y, zero} !== {16'd143, 1'b0}) begin n_err++; $display("FAIL mul_13_11 got y=%h z%b exp y=008f z0", y, zero); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(2'b00, 8'd3, 8'd4);
    wait_valid(lat);
    handshake();
    issue(2'b01, 8'd100, 8'd1);
    wait_valid(lat);
    n_cmp++; if ({lat, y, carry} !== {32'd1, 16'd99, 1'b1}) begin n_err++; $display("FAIL b2b_second got lat=%0d y=%h c%b exp lat=1 y=0063 c1", lat, y, carry); end
    handshake();
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    issue(2'b10, 8'd9, 8'd9);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({out_valid, in_ready, y} !== {2'b00, 16'h0000}) begin n_err++; $display("FAIL rst_mid_mul got vld=%b rdy=%b y=%h exp 0 0 0000", out_valid, in_ready, y); end
    @(negedge clk); rst_n = 1'b1;
    issue(2'b00, 8'd1, 8'd1);
    wait_valid(lat);
    n_cmp++; if ({lat, y} !== {32'd1, 16'd2}) begin n_err++; $display("FAIL rst_then_add got lat=%0d y=%h exp lat=1 y=0002", lat, y); end
    handshake();
  endtask

  task automatic test_wide_mul();
    int lat;
    @(negedge clk);
    op16 = 2'b10; a16 = 16'hFFFF; b16 = 16'hFFFF; v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
    lat = 1;
    while (ov16 !== 1'b1 && lat < 64) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== 16) begin n_err++; $display("FAIL w16_latency got %0d exp 16", lat); end
    n_cmp++; if ({y16, c16, o16, z16, e16} !== {32'hFFFE0001, 4'b0000}) begin n_err++; $display("FAIL w16_mul got y=%h flags=%b%b%b%b exp fffe0001 0000", y16, c16, o16, z16, e16); end
    @(negedge clk); or16 = 1'b1;
    @(posedge clk); #1; or16 = 1'b0;
    n_cmp++; if (r16 !== 1'b1) begin n_err++; $display("FAIL w16_idle got rdy=%b exp 1", r16); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = '0; b = '0;
    v16 = 1'b0; or16 = 1'b0; op16 = 2'b00; a16 = '0; b16 = '0;
    test_reset();
    test_add();
    test_backpressure();
    test_sub();
    test_reserved();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    test_wide_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
